// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: display mode presets and raster timing helpers shared by the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam vga_mode_t MODE_800X600_72 = '{h: '{800, 56, 120, 64}, v: '{600, 37, 6, 23}};

    function automatic int unsigned axis_total(int unsigned active, int unsigned fp, int unsigned sync, int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned len);
        return pos >= lo && pos < lo + len;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel enable in, raster position/sync/strobe outputs to the VGA pins and renderer.
interface vga_timing_gen_if #(parameter int unsigned CNT_W = 10);
    logic             pix_en;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_end;
    logic             frame_start;

    modport master (input pix_en, output h_count, v_count, hsync, vsync, video_on, line_end, frame_start);
    modport slave (output pix_en, input h_count, v_count, hsync, vsync, video_on, line_end, frame_start);
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// axis_counter: enable-gated modulo-(MAX+1) counter exposing its next value and a wrap pulse.
module axis_counter #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned MAX   = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] next_o,
    output logic             wrap_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && count_q == CNT_W'(MAX);
        count_d = wrap_o ? '0 : en_i ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else count_q <= count_d;

    assign count_o = count_q;
    assign next_o  = count_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync, active-video and line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] h_q, h_next, v_q, v_next;
    logic             h_wrap, v_wrap;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic             line_end_q, line_end_d, frame_start_q, frame_start_d;

    axis_counter #(.CNT_W(CNT_W), .MAX(H_TOTAL - 1)) u_h (
        .clk(clk), .reset(reset), .en_i(vga.pix_en),
        .count_o(h_q), .next_o(h_next), .wrap_o(h_wrap)
    );

    axis_counter #(.CNT_W(CNT_W), .MAX(V_TOTAL - 1)) u_v (
        .clk(clk), .reset(reset), .en_i(vga.pix_en && h_wrap),
        .count_o(v_q), .next_o(v_next), .wrap_o(v_wrap)
    );

    // Decoding the next counts keeps every registered flag aligned with the counts it describes.
    always_comb begin
        hsync_d       = in_window(32'(h_next), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
        vsync_d       = in_window(32'(v_next), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
        video_on_d    = 32'(h_next) < H_ACTIVE && 32'(v_next) < V_ACTIVE;
        line_end_d    = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b1;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end

    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_end    = line_end_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a 640x480 build and a tiny inverted-polarity build against a raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        von;
        logic        le;
        logic        fs;
    } exp_t;

    typedef struct {
        int ha, hf, hsy, hb, va, vf, vsy, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        int   adv;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    tim_t tm[2];
    int   mh[2];
    int   mv[2];
    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10)) vif0 ();
    vga_timing_gen_if #(.CNT_W(4)) vif1 ();
    assign vif0.pix_en = pix_en;
    assign vif1.pix_en = pix_en;

    vga_timing_gen dut0 (.clk(clk), .reset(reset), .vga(vif0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut1 (.clk(clk), .reset(reset), .vga(vif1));

    function automatic exp_t mk(int h, int v, bit hs, bit vs, bit von, bit le, bit fs);
        return exp_t'({16'(h), 16'(v), hs, vs, von, le, fs});
    endfunction

    function automatic exp_t expect_at(int i, bit le, bit fs);
        int hlo = tm[i].ha + tm[i].hf;
        int vlo = tm[i].va + tm[i].vf;
        bit hs = (mh[i] >= hlo && mh[i] < hlo + tm[i].hsy) ? tm[i].hp : !tm[i].hp;
        bit vs = (mv[i] >= vlo && mv[i] < vlo + tm[i].vsy) ? tm[i].vp : !tm[i].vp;
        return mk(mh[i], mv[i], hs, vs, mh[i] < tm[i].ha && mv[i] < tm[i].va, le, fs);
    endfunction

    function automatic exp_t step(int i, bit en);
        int ht = tm[i].ha + tm[i].hf + tm[i].hsy + tm[i].hb;
        int vt = tm[i].va + tm[i].vf + tm[i].vsy + tm[i].vb;
        bit le = 1'b0;
        bit fs = 1'b0;
        if (en) begin
            le = mh[i] == ht - 1;
            fs = le && mv[i] == vt - 1;
            mh[i] = le ? 0 : mh[i] + 1;
            if (le) mv[i] = fs ? 0 : mv[i] + 1;
        end
        return expect_at(i, le, fs);
    endfunction

    function automatic exp_t got(int i);
        return i == 0
            ? mk(int'(vif0.h_count), int'(vif0.v_count), vif0.hsync, vif0.vsync, vif0.video_on, vif0.line_end, vif0.frame_start)
            : mk(int'(vif1.h_count), int'(vif1.v_count), vif1.hsync, vif1.vsync, vif1.video_on, vif1.line_end, vif1.frame_start);
    endfunction

    task automatic check(string nm, exp_t g, exp_t e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b von=%b le=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b von=%b le=%b fs=%b",
                     nm, g.h, g.v, g.hs, g.vs, g.von, g.le, g.fs, e.h, e.v, e.hs, e.vs, e.von, e.le, e.fs);
        end
    endtask

    task automatic check_int(string nm, int g, int e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, g, e);
        end
    endtask

    task automatic model_reset();
        mh = '{0, 0};
        mv = '{0, 0};
        q0.delete();
        q1.delete();
    endtask

    task automatic cycle(bit en);
        pix_en = en;
        q0.push_back(step(0, en));
        q1.push_back(step(1, en));
        @(posedge clk);
        #1;
        check("sb0", got(0), q0.pop_front());
        check("sb1", got(1), q1.pop_front());
    endtask

    task automatic seek1(int h, int v);
        int n = 0;
        while (!(mh[1] == h && mv[1] == v) && n < 300) begin
            cycle(1'b1);
            n++;
        end
        check_int($sformatf("seek_%0d_%0d_reached", h, v), int'(mh[1] == h && mv[1] == v), 1);
    endtask

    task automatic frame_len(string nm, int e);
        int n = 0;
        do begin
            cycle(1'b1);
            n++;
        end while (!vif1.frame_start && n < 300);
        check_int(nm, n, e);
    endtask

    initial begin
        tm[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        tm[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
        tbl[0] = '{639, mk(639, 0, 1, 1, 1, 0, 0)};
        tbl[1] = '{1,   mk(640, 0, 1, 1, 0, 0, 0)};
        tbl[2] = '{15,  mk(655, 0, 1, 1, 0, 0, 0)};
        tbl[3] = '{1,   mk(656, 0, 0, 1, 0, 0, 0)};
        tbl[4] = '{95,  mk(751, 0, 0, 1, 0, 0, 0)};
        tbl[5] = '{1,   mk(752, 0, 1, 1, 0, 0, 0)};
        tbl[6] = '{47,  mk(799, 0, 1, 1, 0, 0, 0)};
        tbl[7] = '{1,   mk(0, 1, 1, 1, 1, 1, 0)};
        tbl[8] = '{1,   mk(1, 1, 1, 1, 1, 0, 0)};
        pix_en = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("reset0", got(0), mk(0, 0, 1, 1, 1, 0, 0));
        check("reset1", got(1), mk(0, 0, 0, 0, 1, 0, 0));
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (tbl[i].adv) cycle(1'b1);
            check($sformatf("vec%0d", i), got(0), tbl[i].e);
        end
        repeat (796) cycle(1'b1);
        for (int k = 0; k < 16; k++) begin
            cycle(k % 4 == 0);
            if (k == 8) check("rate_wrap", got(0), mk(0, 2, 1, 1, 1, 1, 0));
            if (k == 9) check("rate_hold", got(0), mk(0, 2, 1, 1, 1, 0, 0));
        end
        seek1(0, 5);
        check("vs_on", got(1), mk(0, 5, 0, 1, 0, 1, 0));
        seek1(12, 6);
        check("hs_last", got(1), mk(12, 6, 1, 1, 0, 0, 0));
        seek1(13, 6);
        check("hs_off", got(1), mk(13, 6, 0, 1, 0, 0, 0));
        seek1(0, 0);
        check("frame_wrap", got(1), mk(0, 0, 0, 0, 1, 1, 1));
        frame_len("frame_period", 120);
        seek1(3, 3);
        reset = 1'b1;
        #2;
        check("arst0", got(0), mk(0, 0, 1, 1, 1, 0, 0));
        check("arst1", got(1), mk(0, 0, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        frame_len("post_reset_frame", 120);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
